// File: rtl/button_debounce_scheduler.sv
// button_debounce_scheduler
//
// Debounces NBTN push-buttons using one shared hold timer. Raw levels are
// synchronised, and the timer is granted round-robin to one button whose
// synchronised level differs from its debounced level. The new level is
// committed only if it holds for DELAY cycles, and a one-cycle press or
// release strobe is raised on commit.
//
// Ports:
//   clk5       system clock, rising edge
//   reset      asynchronous, active-high reset
//   raw_i      bouncy button levels, asynchronous to clk5 (1 = pressed)
//   stable_o   debounced button levels (registered)
//   press_o    one-cycle strobe when stable_o[i] rises
//   release_o  one-cycle strobe when stable_o[i] falls
//   busy_o     shared timer granted (WAIT or COMMIT)
//   owner_o    index of the button holding the timer; holds its value when idle

module button_debounce_scheduler #(
    parameter int unsigned NBTN  = 4,
    parameter int unsigned DELAY = 50000
) (
    input  logic                    clk5,
    input  logic                    reset,
    input  logic [NBTN-1:0]         raw_i,
    output logic [NBTN-1:0]         stable_o,
    output logic [NBTN-1:0]         press_o,
    output logic [NBTN-1:0]         release_o,
    output logic                    busy_o,
    output logic [$clog2(NBTN)-1:0] owner_o
);

    localparam int unsigned IdxW  = $clog2(NBTN);
    localparam int unsigned CandW = IdxW + 1;
    localparam int unsigned TmrW  = $clog2(DELAY);
    localparam logic [TmrW-1:0] TmrMax = TmrW'(DELAY - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(NBTN - 1);

    typedef enum logic [1:0] {StIdle, StWait, StCommit} state_e;

    state_e            state_q, state_d;
    logic [NBTN-1:0]   sync1_q, sync2_q;
    logic [NBTN-1:0]   stable_q, stable_d;
    logic [NBTN-1:0]   press_q, press_d;
    logic [NBTN-1:0]   release_q, release_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [TmrW-1:0]   timer_q, timer_d;

    logic [NBTN-1:0]   mism;
    logic [CandW-1:0]  cand;
    logic              grant_found;
    logic [IdxW-1:0]   grant_idx;
    logic [IdxW-1:0]   owner_inc;

    // Two-flop synchroniser; sync2_q is the synchronised raw level.
    always_ff @(posedge clk5 or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign mism = sync2_q ^ stable_q;

    // Explicit wrap so non-power-of-two NBTN never reaches an unused index.
    assign owner_inc = (owner_q == IdxMax) ? '0 : owner_q + 1'b1;

    // First mismatching button searching ptr, ptr+1, ... modulo NBTN.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NBTN; k++) begin
            cand = {1'b0, ptr_q} + CandW'(k);
            if (cand >= CandW'(NBTN)) begin
                cand = cand - CandW'(NBTN);
            end
            if (!grant_found && mism[cand[IdxW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        timer_d   = timer_q;
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    owner_d = grant_idx;
                    timer_d = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (sync2_q[owner_q] == stable_q[owner_q]) begin
                    // Level bounced back: give up the timer without a strobe.
                    ptr_d   = owner_inc;
                    state_d = StIdle;
                end else if (timer_q == TmrMax) begin
                    state_d = StCommit;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StCommit: begin
                stable_d[owner_q] = ~stable_q[owner_q];
                if (!stable_q[owner_q]) begin
                    press_d[owner_q] = 1'b1;
                end else begin
                    release_d[owner_q] = 1'b1;
                end
                ptr_d   = owner_inc;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk5 or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            owner_q   <= '0;
            timer_q   <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            timer_q   <= timer_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign stable_o  = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign busy_o    = (state_q != StIdle);
    assign owner_o   = owner_q;

endmodule

// File: tb/tb_button_debounce_scheduler.sv
// Directed bench for button_debounce_scheduler with NBTN=4, DELAY=8.
// E0 is the first rising edge after a raw change; checks sit 1 ns after edges.
module tb_button_debounce_scheduler;

    localparam int unsigned NBTN  = 4;
    localparam int unsigned DELAY = 8;

    logic            clk5;
    logic            reset;
    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] stable;
    logic [NBTN-1:0] press;
    logic [NBTN-1:0] release_s;
    logic            busy;
    logic [1:0]      owner;

    int n_vec;
    int n_err;
    int cur;
    int press_cnt   [NBTN];
    int release_cnt [NBTN];
    int overlap_cnt;

    button_debounce_scheduler #(
        .NBTN  (NBTN),
        .DELAY (DELAY)
    ) dut (
        .clk5      (clk5),
        .reset     (reset),
        .raw_i     (raw),
        .stable_o  (stable),
        .press_o   (press),
        .release_o (release_s),
        .busy_o    (busy),
        .owner_o   (owner)
    );

    initial clk5 = 1'b0;
    always #5 clk5 = ~clk5;

    // Strobe bookkeeping, sampled mid-cycle.
    initial begin
        for (int i = 0; i < NBTN; i++) begin
            press_cnt[i]   = 0;
            release_cnt[i] = 0;
        end
        overlap_cnt = 0;
    end

    always @(negedge clk5) begin
        if (!reset) begin
            for (int i = 0; i < NBTN; i++) begin
                press_cnt[i]   <= press_cnt[i] + int'(press[i]);
                release_cnt[i] <= release_cnt[i] + int'(release_s[i]);
            end
            if ($countones(press | release_s) > 1) overlap_cnt <= overlap_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called 1 ns after edge E0-1, i.e. right after changing raw.
    task automatic mark_e0();
        cur = -1;
    endtask

    task automatic after_edge(input int k);
        repeat (k - cur) @(posedge clk5);
        #1;
        cur = k;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cur   = 0;
        reset = 1'b1;
        raw   = '0;
        repeat (3) @(posedge clk5);
        #1;
        check_val("rst_stable", 32'(stable), 32'h0);
        check_val("rst_press", 32'(press), 32'h0);
        check_val("rst_release", 32'(release_s), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_owner", 32'(owner), 32'h0);
        reset = 1'b0;

        // Single press on button 1: grant at E0+2, commit at E0+11.
        raw = 4'b0010;
        mark_e0();
        after_edge(1);
        check_val("t1_busy_pre", 32'(busy), 32'h0);
        after_edge(2);
        check_val("t1_busy_grant", 32'(busy), 32'h1);
        check_val("t1_owner", 32'(owner), 32'h1);
        after_edge(10);
        check_val("t1_busy_late", 32'(busy), 32'h1);
        check_val("t1_stable_late", 32'(stable), 32'h0);
        check_val("t1_press_late", 32'(press), 32'h0);
        after_edge(11);
        check_val("t1_stable", 32'(stable), 32'h2);
        check_val("t1_press", 32'(press), 32'h2);
        check_val("t1_busy_done", 32'(busy), 32'h0);
        after_edge(12);
        check_val("t1_press_end", 32'(press), 32'h0);

        // Bounce on button 2: high 3 cycles, low 1, then held.
        raw = 4'b0110;
        mark_e0();
        after_edge(2);
        check_val("t2_busy_grant", 32'(busy), 32'h1);
        check_val("t2_owner", 32'(owner), 32'h2);
        raw = 4'b0010;
        after_edge(3);
        raw = 4'b0110;
        after_edge(4);
        check_val("t2_busy_wait", 32'(busy), 32'h1);
        after_edge(5);
        check_val("t2_busy_abort", 32'(busy), 32'h0);
        check_val("t2_stable_abort", 32'(stable), 32'h2);
        check_val("t2_press_abort", 32'(press), 32'h0);
        after_edge(6);
        check_val("t2_busy_regrant", 32'(busy), 32'h1);
        after_edge(14);
        check_val("t2_press_early", 32'(press), 32'h0);
        after_edge(15);
        check_val("t2_press", 32'(press), 32'h4);
        check_val("t2_stable", 32'(stable), 32'h6);
        after_edge(16);
        check_val("t2_press_end", 32'(press), 32'h0);
        check_val("t2_press_count", 32'(press_cnt[2]), 32'd1);

        // Fairness: ptr=3 now, so button 3 is granted before button 0.
        raw = 4'b1111;
        mark_e0();
        after_edge(2);
        check_val("t3_owner_first", 32'(owner), 32'h3);
        after_edge(11);
        check_val("t3_press_3", 32'(press), 32'h8);
        after_edge(12);
        check_val("t3_owner_second", 32'(owner), 32'h0);
        check_val("t3_busy_second", 32'(busy), 32'h1);
        after_edge(21);
        check_val("t3_press_0", 32'(press), 32'h1);
        check_val("t3_stable", 32'(stable), 32'hf);
        after_edge(22);

        // Release of button 0.
        raw = 4'b1110;
        mark_e0();
        after_edge(2);
        check_val("t4_owner", 32'(owner), 32'h0);
        after_edge(11);
        check_val("t4_release", 32'(release_s), 32'h1);
        check_val("t4_press", 32'(press), 32'h0);
        check_val("t4_stable", 32'(stable), 32'he);
        after_edge(12);
        check_val("t4_release_end", 32'(release_s), 32'h0);

        // Reset mid-WAIT (button 2 owns the timer) with raw[1] held.
        raw = 4'b0010;
        mark_e0();
        after_edge(4);
        check_val("t5_busy_wait", 32'(busy), 32'h1);
        check_val("t5_owner_wait", 32'(owner), 32'h2);
        reset = 1'b1;
        #1;
        check_val("t5_rst_stable", 32'(stable), 32'h0);
        check_val("t5_rst_busy", 32'(busy), 32'h0);
        check_val("t5_rst_owner", 32'(owner), 32'h0);
        check_val("t5_rst_strobes", 32'(press | release_s), 32'h0);
        repeat (2) @(posedge clk5);
        #1;
        reset = 1'b0;
        mark_e0();
        after_edge(10);
        check_val("t5_press_early", 32'(press), 32'h0);
        after_edge(11);
        check_val("t5_press", 32'(press), 32'h2);
        check_val("t5_stable", 32'(stable), 32'h2);
        after_edge(12);
        check_val("t5_release_total", 32'(release_cnt[2] + release_cnt[3]), 32'd0);

        // Simultaneous rise on buttons 0 and 3 with ptr=0 after reset.
        reset = 1'b1;
        raw   = 4'b0000;
        repeat (2) @(posedge clk5);
        #1;
        reset = 1'b0;
        raw   = 4'b1001;
        mark_e0();
        after_edge(2);
        check_val("t6_owner_first", 32'(owner), 32'h0);
        after_edge(11);
        check_val("t6_press_0", 32'(press), 32'h1);
        after_edge(12);
        check_val("t6_owner_second", 32'(owner), 32'h3);
        check_val("t6_press_gap", 32'(press), 32'h0);
        after_edge(20);
        check_val("t6_press_3_early", 32'(press), 32'h0);
        after_edge(21);
        check_val("t6_press_3", 32'(press), 32'h8);
        check_val("t6_stable", 32'(stable), 32'h9);
        after_edge(22);

        check_val("cnt_press0", 32'(press_cnt[0]), 32'd2);
        check_val("cnt_press1", 32'(press_cnt[1]), 32'd2);
        check_val("cnt_press2", 32'(press_cnt[2]), 32'd1);
        check_val("cnt_press3", 32'(press_cnt[3]), 32'd2);
        check_val("cnt_release0", 32'(release_cnt[0]), 32'd1);
        check_val("cnt_release1", 32'(release_cnt[1]), 32'd0);
        check_val("cnt_overlap", 32'(overlap_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_debounce_scheduler.md
# button_debounce_scheduler

Time-multiplexed debounce controller that shares one delay timer among NBTN raw button inputs. It synchronises every raw input and grants the single timer to one changed button at a time, in round-robin order. It commits the button's new level only if the raw level holds for DELAY cycles. It sits between the board push-buttons and the user logic in the clk5 domain and produces per-button stable levels plus one-cycle press/release strobes.

## Interface
- NBTN, default 4: number of buttons; must be ≥ 2.
- DELAY, default 50000: debounce hold time in clk5 cycles (10 ms at 5 MHz); must be ≥ 2.
- clk5  input  1  system clock; all logic on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- raw  input  NBTN  asynchronous bouncy button levels; 1 = pressed.
- stable  output  NBTN  debounced button levels (registered).
- press  output  NBTN  one-cycle strobe when stable[i] goes 0→1.
- release  output  NBTN  one-cycle strobe when stable[i] goes 1→0.
- busy  output  1  high while the shared timer is granted (WAIT or COMMIT).
- owner  output  $clog2(NBTN)  index of the button holding the timer; holds last value when idle.

## Operation
- Each raw[i] passes through a 2-flop synchroniser, giving sraw[i]. The mismatch vector is m = sraw ^ stable.
- Internal registers:
  - round-robin pointer ptr, $clog2(NBTN) bits;
  - timer, $clog2(DELAY) bits;
  - owner;
  - 3-state FSM: IDLE, WAIT, COMMIT.
- IDLE:
  - If m == 0, stay in IDLE.
  - Otherwise grant the first set bit of m searching ptr, ptr+1, … wrapping modulo NBTN. Load owner with that index, clear timer to 0, and go to WAIT.
- WAIT:
  - If sraw[owner] == stable[owner] (bounce back), abort:
    - ptr ← owner+1 mod NBTN;
    - go to IDLE;
    - no change to stable or strobes.
  - Else if timer == DELAY-1, go to COMMIT.
  - Else timer ← timer+1.
- COMMIT:
  - stable[owner] ← ~stable[owner].
  - Pulse press[owner] if the new level is 1, otherwise pulse release[owner].
  - ptr ← owner+1 mod NBTN; go to IDLE.
- Mismatch is evaluated only in IDLE. Changes on non-owner buttons during WAIT are queued implicitly through m.
- Only one strobe bit of press|release is ever high in a cycle; press and release are never high together.
- The timer never exceeds DELAY-1; the counter does not wrap.
- NBTN not a power of two: the pointer increment wraps explicitly at NBTN-1 → 0. Indices ≥ NBTN are never granted.

## Timing
- Reset values:
  - stable = 0, press = 0, release = 0, busy = 0, owner = 0;
  - ptr = 0, timer = 0, synchroniser flops = 0, FSM in IDLE.
- Reset mid-operation aborts any WAIT or COMMIT with no strobe. A button still held after reset is re-debounced from scratch and yields a press.
- Latency, uncontended: raw[i] changes and is steady before edge E0.
  - sraw[i] changes at E0+1.
  - The grant edge (IDLE→WAIT) is E0+2.
  - WAIT→COMMIT is at E0+2+DELAY.
  - stable[i] and the strobe are updated at edge E0+3+DELAY. The strobe is high for exactly the one cycle following that edge.
- busy is high from the grant edge until the edge that leaves COMMIT or aborts WAIT.
- Contention: a change arriving while the timer is owned waits until IDLE. Worst-case latency is ≈ NBTN·(DELAY+2)+3 cycles.
- Abort detection: a bounce of ≥ 1 cycle seen on sraw[owner] during WAIT aborts within 1 cycle. The button is re-granted on a later IDLE cycle if the mismatch reappears.
- Two or more buttons changing on the same edge are granted in pointer order, one per debounce cycle.

## Test plan
- NBTN=4, DELAY=8; raw[1] 0→1 before edge 10, held -> stable[1]=1 and press[1]=1 for exactly one cycle following edge 21; busy high edges 12–21; owner=1.
- Bounce: raw[2] high 3 cycles, low 1 cycle, then held high -> first grant aborts with no strobe; press[2] arrives DELAY+3 cycles after the final rising edge; exactly one press[2] pulse.
- Release: with stable[0]=1, drop raw[0] and hold -> release[0] one cycle after DELAY+3 cycles; stable[0]=0; press stays 0.
- Simultaneous: raw[0] and raw[3] rise on the same edge with ptr=0 -> press[0] first, then press[3] exactly DELAY+2 cycles later; stable=4'b1001.
- Fairness: ptr=3 after committing button 2; raw[0] and raw[3] both change -> button 3 granted before button 0.
- Reset asserted mid-WAIT with raw[1] held -> all outputs 0 immediately; after release of reset, press[1] after DELAY+3 cycles.
